// File: rtl/dvsd_counter_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// dvsd_counter_sequencer_pkg : state and mode encodings for the sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dvsd_counter_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GOTO = 3'd1,
    S_OUT  = 3'd2,
    S_BACK = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic MODE_GOTO   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dvsd_step_prescaler.sv
// ---------------------------------------------------------------------------
// dvsd_step_prescaler : reloadable down counter producing one tick every div+1 cycles. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dvsd_step_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             run_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_o = run_i && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= div_i;
    end else if (run_i) begin
      cnt_q <= (cnt_q == '0) ? div_i : cnt_q - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dvsd_counter_sequencer.sv
// ---------------------------------------------------------------------------
// dvsd_counter_sequencer : command-driven GOTO/BOUNCE pacing of a 4-bit up/down counter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dvsd_counter_sequencer
  import dvsd_counter_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             updown,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] origin_q;
  logic [REP_W-1:0] reps_q;
  logic [DIV_W-1:0] div_q;
  logic             updown_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;

  logic             accept;
  logic             moving;
  logic             tick;
  logic [DIV_W-1:0] pre_div;
  logic [WIDTH-1:0] out_d;

  assign accept  = cmd_valid && ready_q;
  assign moving  = (state_q == S_GOTO) || (state_q == S_OUT) || (state_q == S_BACK);
  assign pre_div = accept ? cmd_div : div_q;
  assign out_d   = updown_q ? out_q + 1'b1 : out_q - 1'b1;

  dvsd_step_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .div_i  (pre_div),
    .run_i  (moving),
    .tick_o (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      target_q <= '0;
      origin_q <= '0;
      reps_q   <= '0;
      div_q    <= '0;
      updown_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            target_q <= cmd_target;
            reps_q   <= cmd_reps;
            div_q    <= cmd_div;
            origin_q <= out_q;
            ready_q  <= 1'b0;
            if (cmd_mode == MODE_GOTO) begin
              updown_q <= (cmd_target > out_q);
              if (cmd_target == out_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_GOTO;
                busy_q  <= 1'b1;
              end
            end else if ((cmd_reps == '0) || (cmd_target == out_q)) begin
              // Degenerate bounce: no motion, direction left untouched
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              updown_q <= (cmd_target > out_q);
              state_q  <= S_OUT;
              busy_q   <= 1'b1;
            end
          end
        end
        S_GOTO, S_OUT, S_BACK: begin
          // Abort takes priority over a coincident tick: no step on that edge
          if (abort) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (tick) begin
            out_q <= out_d;
            case (state_q)
              S_GOTO: begin
                if (out_d == target_q) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
              S_OUT: begin
                if (out_d == target_q) begin
                  state_q  <= S_BACK;
                  updown_q <= ~updown_q;
                end
              end
              default: begin
                if (out_d == origin_q) begin
                  reps_q <= reps_q - 1'b1;
                  if (reps_q == REP_W'(1)) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end else begin
                    state_q  <= S_OUT;
                    updown_q <= ~updown_q;
                  end
                end
              end
            endcase
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign out       = out_q;
  assign updown    = updown_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dvsd_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dvsd_counter_sequencer : directed and random commands against a trajectory model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dvsd_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_mode = 1'b0;
  logic [3:0] cmd_target = '0;
  logic [3:0] cmd_reps = '0;
  logic [7:0] cmd_div = '0;
  logic       abort = 1'b0;
  logic [3:0] out;
  logic       updown;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  int m_out = 0;
  bit m_up = 1'b0;

  dvsd_counter_sequencer #(
    .WIDTH (4),
    .DIV_W (8),
    .REP_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_target (cmd_target),
    .cmd_reps   (cmd_reps),
    .cmd_div    (cmd_div),
    .abort      (abort),
    .out        (out),
    .updown     (updown),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit e_busy, input bit e_done, input bit e_ready);
    chk({tag, ".out"}, 32'(out), 32'(m_out));
    chk({tag, ".updown"}, 32'(updown), 32'(m_up));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(e_ready));
  endtask

  // Plans the full list of positions/directions, then replays it at div+1 pacing
  task automatic run_cmd(input bit mode, input int tgt, input int reps, input int div,
                         input int abort_k, input bit hold_v);
    int seq_v[$];
    bit seq_u[$];
    int o0, v, n, k, j;
    bit u, moving;
    o0 = m_out;
    if (mode == 1'b0) begin
      u = (tgt > o0);
      m_up = u;
      v = o0;
      while (v != tgt) begin
        v += u ? 1 : -1;
        seq_v.push_back(v);
        seq_u.push_back(u);
      end
    end else if (reps != 0 && tgt != o0) begin
      u = (tgt > o0);
      m_up = u;
      for (int r = 0; r < reps; r++) begin
        v = o0;
        while (v != tgt) begin
          v += u ? 1 : -1;
          seq_v.push_back(v);
          seq_u.push_back((v == tgt) ? !u : u);
        end
        while (v != o0) begin
          v += u ? -1 : 1;
          seq_v.push_back(v);
          seq_u.push_back((v == o0 && r != reps - 1) ? u : !u);
        end
      end
    end
    n = seq_v.size();

    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_mode   = mode;
    cmd_target = 4'(tgt);
    cmd_reps   = 4'(reps);
    cmd_div    = 8'(div);
    @(posedge clk);
    #1;
    chk_all("accept", n != 0, n == 0, 1'b0);

    moving = (n != 0);
    k = 0;
    j = 0;
    while (moving) begin
      @(negedge clk);
      k++;
      cmd_valid = hold_v;
      if (hold_v) begin
        cmd_mode   = 1'($urandom);
        cmd_target = 4'($urandom);
        cmd_reps   = 4'($urandom);
        cmd_div    = 8'($urandom_range(0, 3));
      end
      abort = (k == abort_k);
      @(posedge clk);
      #1;
      if (abort) begin
        moving = 1'b0;
      end else if (k % (div + 1) == 0) begin
        m_out = seq_v[j];
        m_up  = seq_u[j];
        j++;
        if (j == n) moving = 1'b0;
      end
      chk_all("move", moving, !moving, 1'b0);
    end

    @(negedge clk);
    abort = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("idle", 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk_all("reset_async", 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_reset", 1'b0, 1'b0, 1'b1);

    run_cmd(1'b0, 5, 0, 0, 0, 1'b0);   // GOTO 0->5, div 0
    run_cmd(1'b0, 2, 0, 2, 0, 1'b0);   // GOTO 5->2, div 2
    run_cmd(1'b0, 3, 0, 0, 0, 1'b0);
    run_cmd(1'b1, 5, 2, 0, 0, 1'b0);   // BOUNCE 3<->5 x2
    run_cmd(1'b0, 0, 0, 0, 0, 1'b0);
    run_cmd(1'b0, 15, 0, 0, 4, 1'b0);  // abort alongside the E4 tick
    run_cmd(1'b0, 7, 0, 1, 0, 1'b1);   // new command after abort; valid held
    run_cmd(1'b0, 7, 0, 3, 0, 1'b0);   // GOTO target == out
    run_cmd(1'b1, 9, 0, 0, 0, 1'b0);   // BOUNCE reps = 0
    run_cmd(1'b1, 7, 3, 1, 0, 1'b0);   // BOUNCE target == origin
    run_cmd(1'b1, 4, 1, 1, 5, 1'b1);   // abort mid-bounce

    for (int i = 0; i < 25; i++) begin
      run_cmd(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0,
              1'($urandom));
    end

    // Asynchronous reset in the middle of a bounce
    run_cmd(1'b0, 3, 0, 0, 0, 1'b0);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_mode   = 1'b1;
    cmd_target = 4'd5;
    cmd_reps   = 4'd2;
    cmd_div    = 8'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    m_out = 4;
    m_up  = 1'b1;
    chk_all("bounce_e1", 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    m_out = 0;
    m_up  = 1'b0;
    chk_all("mid_reset", 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_all("mid_reset_held", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    run_cmd(1'b0, 2, 0, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
